// File: rtl/register_file_param.sv
// Parametrised register file with byte-lane writes, write-to-read bypass
// and a per-register busy scoreboard for in-flight loads.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [DATA_W/8-1:0]        wbe,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              w_ok;
    logic              r_ok;
    logic [DATA_W-1:0] merged;

    // merged is shared by the write path and every bypass port
    always_comb begin
        w_ok   = we && !(ZERO_REG != 0 && wa == '0);
        r_ok   = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
        merged = regs_q[wa];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) merged[8*i +: 8] = wd[8*i +: 8];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (w_ok) regs_d[wa] = merged;
    end

    // reservation is applied last so it wins over a same-edge completion
    always_comb begin
        busy_d = busy_q;
        if (we)   busy_d[wa]       = 1'b0;
        if (r_ok) busy_d[rsv_addr] = 1'b1;
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = ra[k*ADDR_W +: ADDR_W];
        assign hit = rst_n && w_ok && (wa == a);
        assign rd[k*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && a == '0) ? '0 :
            hit ? merged : regs_q[a];
        assign busy[k] = busy_q[a] & ~(we && (wa == a));
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_register_file_param.sv
// Randomized scoreboard bench for register_file_param against an
// array-based reference model of registers and reservations.
module tb_register_file_param;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NB = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     busy;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [NB-1:0]     wbe;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [AW:0]       busy_cnt;

    always #5 clk = ~clk;

    register_file_param #(
        .DATA_W(DW), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .busy(busy),
        .we(we), .wa(wa), .wd(wd), .wbe(wbe), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    busy;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [DW-1:0] mem [D];
    bit            bsy [D];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r = 0;
        for (int b = 0; b < NB; b++) begin
            int unsigned byte_v;
            byte_v = be[b] ? (nw >> (8*b)) & 8'hFF : (old >> (8*b)) & 8'hFF;
            r = r | (DW'(byte_v) << (8*b));
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            mem[i] = '0;
            bsy[i] = 0;
        end
    endtask

    task automatic step(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be,
                        input logic r, input logic [AW-1:0] radr,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        exp_t x;
        int   n;
        logic [AW-1:0] p;
        @(posedge clk);
        #1;
        we = w; wa = a; wd = d; wbe = be;
        rsv_en = r; rsv_addr = radr;
        ra = {r1, r0};
        x.rd = '0;
        x.busy = '0;
        n = 0;
        for (int i = 0; i < D; i++) n += int'(bsy[i]);
        x.cnt = rst_n ? (AW+1)'(n) : '0;
        for (int k = 0; k < NR; k++) begin
            p = (k == 0) ? r0 : r1;
            if (rst_n && p != 0) begin
                if (w && a == p) begin
                    x.rd[k*DW +: DW] = merge(mem[p], d, be);
                end else begin
                    x.rd[k*DW +: DW] = mem[p];
                    x.busy[k] = bsy[p];
                end
            end
        end
        q.push_back(x);
        if (rst_n) begin
            if (w && a != 0) mem[a] = merge(mem[a], d, be);
            if (w) bsy[a] = 0;
            if (r && radr != 0) bsy[radr] = 1;
        end
    endtask

    task automatic nop(input logic [AW-1:0] r0);
        step(0, 0, 0, 0, 0, 0, r0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd", 64'(rd), 64'(e.rd));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
        end
    end

    initial begin
        rst_n = 1'b0;
        we = 0; wa = 0; wd = 0; wbe = 0;
        rsv_en = 0; rsv_addr = 0; ra = 0;
        model_clear();

        // reset then read
        step(0, 0, 0, 0, 0, 0, 5'd7, 5'd3);
        step(0, 0, 0, 0, 0, 0, 5'd7, 5'd3);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 5'd7, 5'd3);
        #1 chk("reset_rd", 64'(rd), 64'h0);

        // byte-lane write
        step(1, 5, 32'h22310111, 4'b1111, 0, 0, 5, 5);
        step(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 5, 5);
        nop(5);
        #1 chk("byte_lane", 64'(rd[31:0]), 64'h22BB01DD);

        // bypass
        step(1, 9, 32'h22310000, 4'b1111, 0, 0, 0, 0);
        step(1, 9, 32'h12345678, 4'b0011, 0, 0, 9, 9);
        #1 chk("bypass_pre", 64'(rd[31:0]), 64'h22315678);
        nop(9);
        #1 chk("bypass_post", 64'(rd[31:0]), 64'h22315678);

        // zero register
        step(1, 0, 32'hFFFFFFFF, 4'b1111, 1, 0, 0, 0);
        #1 chk("zero_rd", 64'(rd), 64'h0);
        nop(0);
        #1 chk("zero_cnt", 64'(busy_cnt), 64'h0);

        // scoreboard
        step(0, 0, 0, 0, 1, 4, 4, 0);
        step(0, 0, 0, 0, 1, 6, 4, 0);
        nop(4);
        #1 chk("sb_cnt2", 64'(busy_cnt), 64'd2);
        chk("sb_busy4", 64'(busy[0]), 64'd1);
        step(1, 4, 32'h0, 4'b1111, 0, 0, 4, 6);
        #1 chk("sb_clear_same_cycle", 64'(busy[0]), 64'd0);
        nop(4);
        #1 chk("sb_cnt1", 64'(busy_cnt), 64'd1);
        step(1, 6, 32'h5, 4'b1111, 1, 6, 6, 4);
        nop(6);
        #1 chk("sb_rsv_wins", 64'(busy[0]), 64'd1);
        chk("sb_cnt_after", 64'(busy_cnt), 64'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a, r0, r1;
            a  = AW'($urandom_range(0, D-1));
            r0 = ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, D-1));
            r1 = ($urandom_range(0, 3) == 0) ? r0 : AW'($urandom_range(0, D-1));
            step(1'($urandom_range(0, 1)), a, $urandom, NB'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, D-1)),
                 r0, r1);
        end

        // asynchronous reset mid-write
        step(0, 0, 0, 0, 1, 3, 3, 0);
        @(posedge clk);
        #1;
        we = 1; wa = 3; wd = 32'h0000ABCD; wbe = 4'b1111;
        rsv_en = 0; ra = {5'd3, 5'd3};
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd", 64'(rd), 64'h0);
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_cnt", 64'(busy_cnt), 64'h0);
        model_clear();
        we = 0; rsv_en = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        nop(3);
        #1 chk("async_reg3", 64'(rd[31:0]), 64'h0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
